// File: rtl/vin_pixel_packer_pkg.sv
// vin_pack_pkg: slot geometry, FSM states and pixel-to-slot conversion; VIN_PACK_RGB565_EN selects 16-bit RGB565 slots.
package vin_pack_pkg;
`ifdef VIN_PACK_RGB565_EN
  localparam int SLOT_BITS = 16;
`else
  localparam int SLOT_BITS = 32;
`endif
  localparam int PIX_PER_WORD = 128 / SLOT_BITS;
  typedef enum logic {S_SYNC, S_FRAME} state_t;
  function automatic logic [15:0] rgb565(input logic [23:0] p);
    return {p[23:19], p[15:10], p[7:3]};
  endfunction
  function automatic logic [SLOT_BITS-1:0] to_slot(input logic [23:0] p);
`ifdef VIN_PACK_RGB565_EN
    return rgb565(p);
`else
    return {8'h00, p};
`endif
  endfunction
endpackage

// File: rtl/vin_pixel_packer_if.sv
// vin_pixel_packer_if: video input bus plus write-FIFO side of the pixel packer.
interface vin_pixel_packer_if #(parameter int WORD_WIDTH = 128);
  logic vin_vs;
  logic vin_hs;
  logic vin_de;
  logic [23:0] vin_data;
  logic fifo_full;
  logic wr_en;
  logic [WORD_WIDTH-1:0] wr_data;
  modport master (output vin_vs, vin_hs, vin_de, vin_data, fifo_full, input wr_en, wr_data);
  modport slave (input vin_vs, vin_hs, vin_de, vin_data, fifo_full, output wr_en, wr_data);
endinterface

// File: rtl/vin_timing_meter.sv
// vin_timing_meter: registered vs/de edge detection, saturating pixel/line counters and per-frame resolution latch.
module vin_timing_meter #(parameter int CNT_WIDTH = 12) (
  input  logic clk,
  input  logic rst,
  input  logic vs,
  input  logic de,
  input  logic framing,
  output logic de_q,
  output logic vs_rise,
  output logic de_fall,
  output logic [CNT_WIDTH-1:0] meas_width,
  output logic [CNT_WIDTH-1:0] meas_height,
  output logic meas_valid
);
  localparam logic [CNT_WIDTH-1:0] MAX = '1;
  logic vs_q, vs_d, de_d;
  logic [CNT_WIDTH-1:0] pix_cnt, line_cnt, cur_width;
  assign vs_rise = vs_q & ~vs_d;
  assign de_fall = de_d & ~de_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      {vs_q, vs_d, de_q, de_d} <= '0;
      pix_cnt <= '0;
      line_cnt <= '0;
      cur_width <= '0;
      meas_width <= '0;
      meas_height <= '0;
      meas_valid <= 1'b0;
    end else begin
      {vs_q, vs_d, de_q, de_d} <= {vs, vs_q, de, de_q};
      if (vs_rise) begin
        if (framing) begin
          meas_width <= cur_width;
          meas_height <= line_cnt;
          meas_valid <= line_cnt != '0;
        end
        pix_cnt <= '0;
        line_cnt <= '0;
        cur_width <= '0;
      end else if (de_fall) begin
        line_cnt <= line_cnt + CNT_WIDTH'(line_cnt != MAX);
        cur_width <= pix_cnt;
        pix_cnt <= '0;
      end else if (de_q) begin
        pix_cnt <= pix_cnt + CNT_WIDTH'(pix_cnt != MAX);
      end
    end
  end
endmodule

// File: rtl/vin_pixel_packer.sv
// vin_pixel_packer: packs DE-qualified pixels into FIFO words with line-end flush and drop-on-full; VIN_PACK_RGB565_EN selects RGB565 slots.
module vin_pixel_packer import vin_pack_pkg::*; #(
  parameter int WORD_WIDTH = 128,
  parameter int CNT_WIDTH = 12
) (
  input  logic clk,
  input  logic rst,
  vin_pixel_packer_if.slave bus,
  input  logic ovf_clr,
  output logic frame_start,
  output logic overflow,
  output logic [CNT_WIDTH-1:0] meas_width,
  output logic [CNT_WIDTH-1:0] meas_height,
  output logic meas_valid
);
  localparam int PPW = WORD_WIDTH / SLOT_BITS;
  localparam int KW = PPW > 1 ? $clog2(PPW) : 1;
  state_t state, state_n;
  logic [23:0] data_q;
  logic de_q, vs_rise, de_fall, pix, last, emit;
  logic [KW-1:0] k;
  logic [WORD_WIDTH-1:0] acc, acc_n, word;
  vin_timing_meter #(.CNT_WIDTH(CNT_WIDTH)) u_meter (
    .clk(clk), .rst(rst), .vs(bus.vin_vs), .de(bus.vin_de), .framing(state == S_FRAME),
    .de_q(de_q), .vs_rise(vs_rise), .de_fall(de_fall),
    .meas_width(meas_width), .meas_height(meas_height), .meas_valid(meas_valid)
  );
  always_ff @(posedge clk) begin
    if (rst) state <= S_SYNC;
    else state <= state_n;
  end
  always_comb begin
    state_n = vs_rise ? S_FRAME : state;
  end
  // a vs edge outranks any pixel or line end in the same cycle, so pending slots are discarded
  assign pix = de_q && state == S_FRAME && !vs_rise;
  assign last = k == KW'(PPW - 1);
  assign emit = pix ? last : (de_fall && !vs_rise && k != '0);
  assign word = pix ? acc_n : acc;
  always_comb begin
    acc_n = acc;
    acc_n[k*SLOT_BITS +: SLOT_BITS] = to_slot(data_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      k <= '0;
      acc <= '0;
      bus.wr_en <= 1'b0;
      bus.wr_data <= '0;
      frame_start <= 1'b0;
      overflow <= 1'b0;
    end else begin
      data_q <= bus.vin_data;
      frame_start <= vs_rise;
      bus.wr_en <= emit && !bus.fifo_full;
      if (emit && !bus.fifo_full) bus.wr_data <= word;
      overflow <= (emit && bus.fifo_full) || (overflow && !ovf_clr);
      if (vs_rise || emit) begin
        k <= '0;
        acc <= '0;
      end else if (pix) begin
        k <= k + 1'b1;
        acc <= acc_n;
      end
    end
  end
endmodule

// File: tb/tb_vin_pixel_packer.sv
// tb_vin_pixel_packer: randomized and directed stimulus checked against a queue-based reference model.
module tb_vin_pixel_packer;
  localparam int WW = 128;
  localparam int CW = 12;
  localparam int SAT = 4095;
`ifdef VIN_PACK_RGB565_EN
  localparam int SB = 16;
`else
  localparam int SB = 32;
`endif
  localparam int PPW = WW / SB;
  typedef struct packed {logic vs; logic de; logic [23:0] d; logic full; logic clr;} in_t;
  logic clk = 0, rst = 1, ovf_clr = 0;
  logic frame_start, overflow, meas_valid;
  logic [CW-1:0] meas_width, meas_height;
  vin_pixel_packer_if #(.WORD_WIDTH(WW)) bus();
  vin_pixel_packer #(.WORD_WIDTH(WW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .ovf_clr(ovf_clr), .frame_start(frame_start),
    .overflow(overflow), .meas_width(meas_width), .meas_height(meas_height), .meas_valid(meas_valid)
  );
  always #5 clk = ~clk;
  int npass = 0, nchk = 0, nfs = 0;
  logic [127:0] got[$];
  in_t h1, h2;
  bit started, pvs, pde, ovf, mv, efs, ewe;
  int pcnt, lines, width, mw, mh;
  int unsigned q[$];
  logic [127:0] ewd;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nchk++;
    if (obs === exp) npass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
  endtask
  function automatic in_t mk(bit vs, bit de, logic [23:0] d, bit full = 0, bit clr = 0);
    mk = {vs, de, d, full, clr};
  endfunction
  function automatic int unsigned slot(logic [23:0] d);
`ifdef VIN_PACK_RGB565_EN
    return ((d >> 19) & 31) * 2048 + ((d >> 10) & 63) * 32 + ((d >> 3) & 31);
`else
    return {8'h00, d};
`endif
  endfunction
  function automatic int sat(int v);
    return v > SAT ? SAT : v;
  endfunction
  // outputs seen now answer the inputs driven two cycles ago; fifo_full/ovf_clr one cycle ago
  task automatic step_model();
    bit vr, df, emit;
    logic [127:0] w;
    vr = h2.vs && !pvs;
    df = !h2.de && pde;
    emit = 0;
    efs = vr;
    ewe = 0;
    if (vr) begin
      if (started) begin mw = width; mh = lines; mv = lines != 0; end
      started = 1; q.delete(); pcnt = 0; lines = 0; width = 0;
    end else begin
      if (h2.de) begin
        pcnt = sat(pcnt + 1);
        if (started) q.push_back(slot(h2.d));
        emit = q.size() == PPW;
      end
      if (df) begin
        emit = q.size() > 0;
        lines = sat(lines + 1);
        width = pcnt;
        pcnt = 0;
      end
    end
    if (emit) begin
      w = 0;
      foreach (q[i]) w = w + (128'(q[i]) << (i * SB));
      q.delete();
      if (!h1.full) begin ewe = 1; ewd = w; end
    end
    ovf = (emit && h1.full) || (ovf && !h1.clr);
    pvs = h2.vs;
    pde = h2.de;
  endtask
  task automatic cyc(input in_t n);
    @(negedge clk);
    step_model();
    chk("wr_en", bus.wr_en, ewe);
    chk("wr_data", bus.wr_data, ewd);
    chk("frame_start", frame_start, efs);
    chk("overflow", overflow, ovf);
    chk("meas_width", meas_width, mw);
    chk("meas_height", meas_height, mh);
    chk("meas_valid", meas_valid, mv);
    if (bus.wr_en) got.push_back(bus.wr_data);
    if (frame_start) nfs++;
    h2 = h1;
    h1 = n;
    bus.vin_vs = n.vs;
    bus.vin_hs = !n.de;
    bus.vin_de = n.de;
    bus.vin_data = n.d;
    bus.fifo_full = n.full;
    ovf_clr = n.clr;
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(mk(0, 0, 0));
  endtask
  task automatic px(input logic [23:0] d, input bit full = 0, input bit clr = 0);
    cyc(mk(0, 1, d, full, clr));
  endtask
  task automatic vsync();
    cyc(mk(1, 0, 0));
    cyc(mk(1, 0, 0));
    idle(3);
  endtask
  logic [127:0] ew;
  int n;
  bit cut;
  initial begin
    bus.vin_vs = 0; bus.vin_hs = 0; bus.vin_de = 0; bus.vin_data = 0; bus.fifo_full = 0;
    h1 = '0; h2 = '0; ewd = '0;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_meas_valid", meas_valid, 0);
    rst = 0;
    // pixels before the first vsync are ignored
    for (int i = 0; i < 6; i++) px(24'h0ABC00 + 24'(i));
    idle(4);
    chk("t1_no_wr", got.size(), 0);
    chk("t1_no_fs", nfs, 0);
    vsync();
    chk("t2_fs_once", nfs, 1);
    got.delete();
    for (int i = 1; i <= 8; i++) px(24'(i));
    idle(4);
`ifndef VIN_PACK_RGB565_EN
    chk("t2_words", got.size(), 2);
    chk("t2_w0", got[0], 128'h00000004_00000003_00000002_00000001);
    chk("t2_w1", got[1], 128'h00000008_00000007_00000006_00000005);
`endif
    got.delete();
    for (int i = 0; i < 6; i++) px(24'hAAAAAA);
    idle(4);
`ifndef VIN_PACK_RGB565_EN
    chk("t3_w0", got[0], {4{32'h00AAAAAA}});
    chk("t3_w1", got[1], 128'h00000000_00000000_00AAAAAA_00AAAAAA);
`endif
    got.delete();
    for (int i = 1; i <= 2 * PPW; i++) px(24'h100 + 24'(i), i > PPW + 1);
    cyc(mk(0, 0, 0, 1));
    idle(3);
    chk("t4_one_word", got.size(), 1);
    chk("t4_ovf_set", overflow, 1);
    cyc(mk(0, 0, 0, 0, 1));
    idle(2);
    chk("t4_ovf_clr", overflow, 0);
    for (int i = 1; i <= PPW; i++) px(24'h200 + 24'(i));
    cyc(mk(0, 0, 0, 1, 1));
    idle(2);
    chk("t4_set_wins", overflow, 1);
    cyc(mk(0, 0, 0, 0, 1));
    idle(2);
    vsync();
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < 1920; i++) px(24'($urandom()));
      idle(8);
    end
    vsync();
    chk("t5_width", meas_width, 1920);
    chk("t5_height", meas_height, 3);
    chk("t5_valid", meas_valid, 1);
    idle(5);
    vsync();
    chk("t5_empty_height", meas_height, 0);
    chk("t5_empty_valid", meas_valid, 0);
    // vsync arriving with two pixels pending mid-line
    got.delete();
    nfs = 0;
    px(24'h111111);
    px(24'h222222);
    cyc(mk(1, 0, 0));
    cyc(mk(1, 0, 0));
    idle(2);
    ew = '0;
    for (int i = 0; i < PPW; i++) begin
      px(24'h300000 + 24'(i));
      ew = ew + (128'(slot(24'h300000 + 24'(i))) << (i * SB));
    end
    idle(4);
    chk("t6_fs", nfs, 1);
    chk("t6_words", got.size(), 1);
    chk("t6_slot0", got[0], ew);
    got.delete();
    for (int i = 0; i < PPW; i++) px(24'hFF0000);
    idle(4);
`ifdef VIN_PACK_RGB565_EN
    chk("t6_rgb565", got[0], {8{16'hF800}});
`else
    chk("t6_rgb888", got[0], {4{32'h00FF0000}});
`endif
    vsync();
    for (int l = 0; l < 4096; l++) begin px(24'h5); idle(1); end
    for (int i = 0; i < 4100; i++) px(24'h6);
    idle(2);
    vsync();
    chk("sat_width", meas_width, SAT);
    chk("sat_height", meas_height, SAT);
    chk("sat_valid", meas_valid, 1);
    repeat (30) begin
      vsync();
      repeat ($urandom_range(0, 4)) begin
        n = $urandom_range(1, 12);
        cut = $urandom_range(0, 7) == 0;
        for (int i = 0; i < n; i++) px(24'($urandom()), $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0);
        if (cut) begin cyc(mk(1, 0, 0)); cyc(mk(1, 0, 0)); end
        repeat ($urandom_range(1, 3)) cyc(mk(0, 0, 0, $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0));
      end
    end
    idle(6);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
